joypad_ctrl: RTL and testbench

JOYPAD_CTRL -- requirements
Module: joypad_ctrl

---
 rtl/joypad_pkg.sv | 29 ++
 rtl/joypad_debounce.sv | 39 +++
 rtl/joypad_ctrl.sv | 82 ++++++++
 tb/tb_joypad_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/joypad_pkg.sv
// Shared definitions for the joypad / P1 register block: bus address,
// interrupt bit position, button indices and the P1 nibble selection rule.
package joypad_pkg;

    localparam logic [15:0] P1_ADDR       = 16'hFF00;
    localparam int          IF_JOYPAD_BIT = 4;
    localparam int          NUM_BUTTONS   = 8;

    typedef enum logic [2:0] {
        BTN_RIGHT  = 3'd0,
        BTN_LEFT   = 3'd1,
        BTN_UP     = 3'd2,
        BTN_DOWN   = 3'd3,
        BTN_A      = 3'd4,
        BTN_B      = 3'd5,
        BTN_SELECT = 3'd6,
        BTN_START  = 3'd7
    } button_e;

    // A group is visible when its select line is low; both low ANDs the groups.
    function automatic logic [3:0] p1_nibble(input logic [1:0] sel, input logic [7:0] btn);
        logic [3:0] nib;
        nib = 4'hF;
        if (!sel[0]) nib = nib & {btn[BTN_DOWN], btn[BTN_UP], btn[BTN_LEFT], btn[BTN_RIGHT]};
        if (!sel[1]) nib = nib & {btn[BTN_START], btn[BTN_SELECT], btn[BTN_B], btn[BTN_A]};
        return nib;
    endfunction

endpackage

// File: rtl/joypad_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one joypad pin.
// The debounced level only follows the pin after DEBOUNCE_CYCLES stable samples.
module joypad_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4500
) (
    input  logic cpu_clk,
    input  logic rst,
    input  logic pin,
    output logic debounced
);

    localparam logic [15:0] LAST_COUNT = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync_meta;
    logic        sync;
    logic [15:0] count;

    // Any agreement between sync and debounced restarts the stability count.
    always_ff @(posedge cpu_clk) begin
        if (!rst) begin
            sync_meta <= 1'b1;
            sync      <= 1'b1;
            debounced <= 1'b1;
            count     <= 16'd0;
        end else begin
            sync_meta <= pin;
            sync      <= sync_meta;
            if (sync == debounced) begin
                count <= 16'd0;
            end else if (count == LAST_COUNT) begin
                debounced <= sync;
                count     <= 16'd0;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/joypad_ctrl.sv
// P1 joypad register: eight debounced button pins, CPU-selectable button
// group, bus read mux and a one-cycle interrupt on any visible press.
module joypad_ctrl
    import joypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4500
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic        joypad_up,
    input  logic        joypad_down,
    input  logic        joypad_left,
    input  logic        joypad_right,
    input  logic        joypad_a,
    input  logic        joypad_b,
    input  logic        joypad_select,
    input  logic        joypad_start,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        we,
    input  logic        re,
    output logic [7:0]  data_out,
    output logic        p1_hit,
    output logic        joypad_irq
);

    logic [NUM_BUTTONS-1:0] raw_pins;
    logic [NUM_BUTTONS-1:0] btn_state;
    logic [1:0]             sel;
    logic [3:0]             nibble;
    logic [3:0]             prev_nibble;
    logic                   addr_match;
    logic                   unused_data_bits;

    always_comb begin
        raw_pins             = '1;
        raw_pins[BTN_RIGHT]  = joypad_right;
        raw_pins[BTN_LEFT]   = joypad_left;
        raw_pins[BTN_UP]     = joypad_up;
        raw_pins[BTN_DOWN]   = joypad_down;
        raw_pins[BTN_A]      = joypad_a;
        raw_pins[BTN_B]      = joypad_b;
        raw_pins[BTN_SELECT] = joypad_select;
        raw_pins[BTN_START]  = joypad_start;
    end

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_pin
        joypad_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .cpu_clk  (cpu_clk),
            .rst      (rst),
            .pin      (raw_pins[i]),
            .debounced(btn_state[i])
        );
    end

    assign addr_match       = (addr == P1_ADDR);
    assign unused_data_bits = ^{data_in[7:6], data_in[3:0]};

    // The nibble comes from the registered sel, so a sel write shows up one
    // cycle later and the irq compare in the write cycle sees the old groups.
    always_comb begin
        nibble   = p1_nibble(sel, btn_state);
        p1_hit   = addr_match && (re || we);
        data_out = 8'hFF;
        if (re && addr_match) data_out = {2'b11, sel, nibble};
    end

    always_ff @(posedge cpu_clk) begin
        if (!rst) begin
            sel         <= 2'b11;
            prev_nibble <= 4'hF;
            joypad_irq  <= 1'b0;
        end else begin
            if (we && addr_match) sel <= data_in[5:4];
            prev_nibble <= nibble;
            joypad_irq  <= |(prev_nibble & ~nibble);
        end
    end

endmodule

// File: tb/tb_joypad_ctrl.sv
// Self-checking bench for joypad_ctrl: directed scenarios followed by random
// pin/bus activity, all compared against a sliding-window reference model.
module tb_joypad_ctrl;
    import joypad_pkg::*;

    localparam int DB = 4;

    logic        cpu_clk = 1'b0;
    logic        rst;
    logic [7:0]  pins;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        we;
    logic        re;
    logic [7:0]  data_out;
    logic        p1_hit;
    logic        joypad_irq;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: last DB+2 raw samples per pin, bit 0 newest.
    logic [DB+1:0] m_hist [8];
    logic [7:0]    m_deb;
    logic [1:0]    m_sel;
    logic [3:0]    m_prev;
    logic          m_irq;

    joypad_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .cpu_clk      (cpu_clk),
        .rst          (rst),
        .joypad_up    (pins[BTN_UP]),
        .joypad_down  (pins[BTN_DOWN]),
        .joypad_left  (pins[BTN_LEFT]),
        .joypad_right (pins[BTN_RIGHT]),
        .joypad_a     (pins[BTN_A]),
        .joypad_b     (pins[BTN_B]),
        .joypad_select(pins[BTN_SELECT]),
        .joypad_start (pins[BTN_START]),
        .addr         (addr),
        .data_in      (data_in),
        .we           (we),
        .re           (re),
        .data_out     (data_out),
        .p1_hit       (p1_hit),
        .joypad_irq   (joypad_irq)
    );

    always #5 cpu_clk = ~cpu_clk;

    function automatic logic [3:0] modelNibble();
        logic [3:0] dirs;
        logic [3:0] acts;
        logic [3:0] result;
        dirs   = {m_deb[3], m_deb[2], m_deb[1], m_deb[0]};
        acts   = {m_deb[7], m_deb[6], m_deb[5], m_deb[4]};
        result = 4'hF;
        if (m_sel[0] == 1'b0) result = result & dirs;
        if (m_sel[1] == 1'b0) result = result & acts;
        return result;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkModel();
        logic [7:0] exp_data;
        exp_data = 8'hFF;
        if (re && addr == 16'hFF00) exp_data = {2'b11, m_sel, modelNibble()};
        checkOutput("model_data_out", data_out, exp_data);
        checkOutput("model_irq", {7'd0, joypad_irq}, {7'd0, m_irq});
        checkOutput("model_p1_hit", {7'd0, p1_hit}, {7'd0, (addr == 16'hFF00) && (re || we)});
    endtask

    // Advance one edge at a time: a pin is accepted once its last DB synchronized
    // samples (ignoring the two newest still in the synchronizer) all disagree.
    task automatic applyStimulus(input int cycles);
        logic [3:0] cur;
        for (int c = 0; c < cycles; c++) begin
            cur = modelNibble();
            @(posedge cpu_clk);
            if (!rst) begin
                for (int i = 0; i < 8; i++) m_hist[i] = '1;
                m_deb  = 8'hFF;
                m_sel  = 2'b11;
                m_prev = 4'hF;
                m_irq  = 1'b0;
            end else begin
                m_irq  = |(m_prev & ~cur);
                m_prev = cur;
                if (we && addr == 16'hFF00) m_sel = data_in[5:4];
                for (int i = 0; i < 8; i++) begin
                    m_hist[i] = {m_hist[i][DB:0], pins[i]};
                    if (m_hist[i][DB+1:2] == {DB{~m_deb[i]}}) m_deb[i] = ~m_deb[i];
                end
            end
            #1;
            checkModel();
        end
    endtask

    task automatic busWrite(input logic [7:0] value);
        addr    = 16'hFF00;
        data_in = value;
        we      = 1'b1;
        applyStimulus(1);
        we      = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_hist[i] = '1;
        m_deb   = 8'hFF;
        m_sel   = 2'b11;
        m_prev  = 4'hF;
        m_irq   = 1'b0;
        rst     = 1'b0;
        pins    = 8'hFF;
        addr    = 16'h0000;
        data_in = 8'h00;
        we      = 1'b0;
        re      = 1'b0;

        // Reset state with bus idle
        applyStimulus(3);
        checkOutput("reset_data_out", data_out, 8'hFF);
        checkOutput("reset_p1_hit", {7'd0, p1_hit}, 8'h00);
        checkOutput("reset_irq", {7'd0, joypad_irq}, 8'h00);
        rst = 1'b1;
        applyStimulus(2);

        // Down press with P14 selected: debounced on edge 6, irq on edge 7
        busWrite(8'h20);
        re = 1'b1;
        pins[BTN_DOWN] = 1'b0;
        applyStimulus(5);
        checkOutput("down_before_accept", data_out, 8'hEF);
        checkOutput("p1_hit_read", {7'd0, p1_hit}, 8'h01);
        applyStimulus(1);
        checkOutput("down_accepted", data_out, 8'hE7);
        checkOutput("down_irq_edge6", {7'd0, joypad_irq}, 8'h00);
        applyStimulus(1);
        checkOutput("down_irq_edge7", {7'd0, joypad_irq}, 8'h01);
        applyStimulus(1);
        checkOutput("down_irq_edge8", {7'd0, joypad_irq}, 8'h00);
        pins[BTN_DOWN] = 1'b1;
        applyStimulus(8);
        checkOutput("down_release_no_irq", {7'd0, joypad_irq}, 8'h00);
        checkOutput("down_release_data", data_out, 8'hEF);

        // Three-cycle glitch on A is rejected
        busWrite(8'h10);
        pins[BTN_A] = 1'b0;
        applyStimulus(3);
        pins[BTN_A] = 1'b1;
        applyStimulus(8);
        checkOutput("glitch_data", data_out, 8'hDF);
        checkOutput("glitch_irq", {7'd0, joypad_irq}, 8'h00);

        // Start held while hidden, then revealed by a select write
        busWrite(8'h30);
        pins[BTN_START] = 1'b0;
        applyStimulus(8);
        checkOutput("start_hidden", data_out, 8'hFF);
        busWrite(8'h10);
        checkOutput("start_revealed", data_out, 8'hD7);
        checkOutput("start_irq_write_edge", {7'd0, joypad_irq}, 8'h00);
        applyStimulus(1);
        checkOutput("start_irq_pulse", {7'd0, joypad_irq}, 8'h01);
        applyStimulus(1);
        checkOutput("start_irq_end", {7'd0, joypad_irq}, 8'h00);
        pins[BTN_START] = 1'b1;
        applyStimulus(8);

        // Both groups selected: right and A overlap on bit 0
        busWrite(8'h00);
        pins[BTN_RIGHT] = 1'b0;
        pins[BTN_A]     = 1'b0;
        applyStimulus(8);
        checkOutput("both_groups", data_out, 8'hCE);
        pins[BTN_RIGHT] = 1'b1;
        applyStimulus(8);
        checkOutput("right_released", data_out, 8'hCE);
        checkOutput("right_released_irq", {7'd0, joypad_irq}, 8'h00);
        pins[BTN_A] = 1'b1;
        applyStimulus(8);

        // Reset in the middle of a debounce discards the partial count
        pins[BTN_DOWN] = 1'b0;
        applyStimulus(2);
        rst = 1'b0;
        applyStimulus(2);
        checkOutput("midreset_data", data_out, 8'hFF);
        checkOutput("midreset_irq", {7'd0, joypad_irq}, 8'h00);
        rst = 1'b1;
        busWrite(8'h20);
        checkOutput("post_reset_first_irq", {7'd0, joypad_irq}, 8'h00);
        applyStimulus(4);
        checkOutput("post_reset_not_yet", data_out, 8'hEF);
        applyStimulus(1);
        checkOutput("post_reset_accept", data_out, 8'hE7);
        applyStimulus(1);
        checkOutput("post_reset_irq", {7'd0, joypad_irq}, 8'h01);
        pins[BTN_DOWN] = 1'b1;
        applyStimulus(8);

        // Neighbouring address is not decoded
        addr = 16'hFF01;
        re   = 1'b1;
        applyStimulus(1);
        checkOutput("ff01_data", data_out, 8'hFF);
        checkOutput("ff01_hit", {7'd0, p1_hit}, 8'h00);

        // Random pins, bus traffic and occasional resets
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 5) == 0) pins[i] = ~pins[i];
            end
            we      = ($urandom_range(0, 7) == 0);
            re      = ($urandom_range(0, 1) == 1);
            addr    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFF00;
            data_in = 8'($urandom);
            rst     = ($urandom_range(0, 149) != 0);
            applyStimulus(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
